// File: rtl/correlate_sequencer.sv
// correlate_sequencer
//   Pairs the left and right census bit-vector streams beat-for-beat, tags
//   each pair with raster X/Y and issues it to the correlator. Owns frame
//   alignment (SYNC on SOF), resynchronisation after an SOF mismatch and
//   frame bookkeeping.
//
//   Optional feature macro: CORRELATE_SEQ_FLUSH_EN
//     defined   -> after each frame, DISP-1 all-zero pairs (x = 0..DISP-2,
//                  y = 0) are issued to drain the correlator pipeline.
//     undefined -> no flush state; the row tail drains with the next frame.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   enable                      run request (sampled in IDLE / at frame end)
//   left_bv/valid/sof/ready     left census stream (valid/ready handshake)
//   right_bv/valid/sof/ready    right census stream (valid/ready handshake)
//   left_bitvec, right_bitvec   issued pair (registered)
//   bitvec_val                  one-cycle strobe per issued pair
//   input_x, input_y            raster coordinates of the issued pair
//   frame_done                  pulse with the last pixel of a frame
//   frame_count                 completed frames (wraps)
//   sync_err                    sticky SOF mismatch flag
//   busy                        state is not IDLE
module correlate_sequencer #(
    parameter int BV_LEN   = 72,
    parameter int F_WIDTH  = 320,
    parameter int F_HEIGHT = 240,
    parameter int DISP     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [BV_LEN-1:0] left_bv,
    input  logic              left_valid,
    input  logic              left_sof,
    output logic              left_ready,
    input  logic [BV_LEN-1:0] right_bv,
    input  logic              right_valid,
    input  logic              right_sof,
    output logic              right_ready,
    output logic [BV_LEN-1:0] left_bitvec,
    output logic [BV_LEN-1:0] right_bitvec,
    output logic              bitvec_val,
    output logic [9:0]        input_x,
    output logic [9:0]        input_y,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              sync_err,
    output logic              busy
);

    // Coordinates are 10 bits wide; the flush needs at least one beat.
    if (F_WIDTH < 2 || F_WIDTH > 1024 || F_HEIGHT < 1 || F_HEIGHT > 1024 || DISP < 2) begin : g_param_check
        $error("correlate_sequencer: F_WIDTH/F_HEIGHT/DISP out of range");
    end

    localparam logic [9:0] X_LAST = 10'(F_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(F_HEIGHT - 1);

`ifdef CORRELATE_SEQ_FLUSH_EN
    typedef enum logic [1:0] {IDLE, SYNC, RUN, FLUSH} state_t;
    localparam int FCW = $clog2(DISP);
    localparam logic [FCW-1:0] FC_LAST = FCW'(DISP - 2);
    logic [FCW-1:0] fc;
`else
    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
`endif

    state_t     state, state_next;
    logic [9:0] x, y;
    logic       at_origin, both_valid, sof_ok, take, mismatch, last_px;

    always_comb begin
        at_origin  = (x == '0) && (y == '0);
        both_valid = left_valid && right_valid;
        // SOF must agree on both sides, and may only appear at (0,0).
        // A mid-frame double SOF is a mismatch, so it is not consumed either.
        sof_ok     = (left_sof == right_sof) && (!left_sof || at_origin);
        take       = (state == RUN) && both_valid && sof_ok;
        mismatch   = (state == RUN) && both_valid && !sof_ok;
        last_px    = (x == X_LAST) && (y == Y_LAST);
    end

    always_comb begin
        state_next  = state;
        left_ready  = 1'b0;
        right_ready = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = SYNC;
            end
            SYNC: begin
                // Discard non-SOF heads; hold SOF heads until both are present.
                left_ready  = left_valid && !left_sof;
                right_ready = right_valid && !right_sof;
                if (left_valid && left_sof && right_valid && right_sof)
                    state_next = RUN;
            end
            RUN: begin
                left_ready  = take;
                right_ready = take;
                if (mismatch) begin
                    state_next = SYNC;
                end else if (take && last_px) begin
`ifdef CORRELATE_SEQ_FLUSH_EN
                    state_next = FLUSH;
`else
                    state_next = enable ? RUN : IDLE;
`endif
                end
            end
`ifdef CORRELATE_SEQ_FLUSH_EN
            FLUSH: begin
                if (fc == FC_LAST) state_next = enable ? RUN : IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x            <= '0;
            y            <= '0;
            left_bitvec  <= '0;
            right_bitvec <= '0;
            input_x      <= '0;
            input_y      <= '0;
            bitvec_val   <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
            sync_err     <= 1'b0;
`ifdef CORRELATE_SEQ_FLUSH_EN
            fc           <= '0;
`endif
        end else begin
            bitvec_val <= 1'b0;
            frame_done <= 1'b0;
            if (take) begin
                left_bitvec  <= left_bv;
                right_bitvec <= right_bv;
                input_x      <= x;
                input_y      <= y;
                bitvec_val   <= 1'b1;
                if (last_px) begin
                    x           <= '0;
                    y           <= '0;
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                end else if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 10'd1;
                end else begin
                    x <= x + 10'd1;
                end
            end else if (mismatch) begin
                x        <= '0;
                y        <= '0;
                sync_err <= 1'b1;
            end
`ifdef CORRELATE_SEQ_FLUSH_EN
            if (state == FLUSH) begin
                left_bitvec  <= '0;
                right_bitvec <= '0;
                input_x      <= 10'(fc);
                input_y      <= '0;
                bitvec_val   <= 1'b1;
                fc           <= (fc == FC_LAST) ? '0 : fc + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_correlate_sequencer.sv
// Directed testbench for correlate_sequencer: reset state, clean frame,
// skewed start, backpressure, SOF mismatch, asynchronous reset and (when
// CORRELATE_SEQ_FLUSH_EN is defined) the end-of-frame flush. A reduced
// frame geometry keeps the run short while keeping the mismatch point
// (100,3) and the reset point (200,50) inside the frame.
module tb_correlate_sequencer;

    localparam int BV = 72;
    localparam int W  = 210;
    localparam int H  = 60;
    localparam int D  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [BV-1:0] left_bv, right_bv;
    logic          left_valid, left_sof, left_ready;
    logic          right_valid, right_sof, right_ready;
    logic [BV-1:0] left_bitvec, right_bitvec;
    logic          bitvec_val;
    logic [9:0]    input_x, input_y;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          sync_err;
    logic          busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    correlate_sequencer #(
        .BV_LEN  (BV),
        .F_WIDTH (W),
        .F_HEIGHT(H),
        .DISP    (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .left_bv     (left_bv),
        .left_valid  (left_valid),
        .left_sof    (left_sof),
        .left_ready  (left_ready),
        .right_bv    (right_bv),
        .right_valid (right_valid),
        .right_sof   (right_sof),
        .right_ready (right_ready),
        .left_bitvec (left_bitvec),
        .right_bitvec(right_bitvec),
        .bitvec_val  (bitvec_val),
        .input_x     (input_x),
        .input_y     (input_y),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .sync_err    (sync_err),
        .busy        (busy)
    );

    function automatic logic [BV-1:0] lvec(input int unsigned s);
        return {8'hA1, 32'h0, s};
    endfunction

    function automatic logic [BV-1:0] rvec(input int unsigned s);
        return {8'hB2, 32'h0, s};
    endfunction

    // Assert reset for one edge with all inputs idle; returns at posedge+1.
    task automatic apply_reset();
        reset       = 1'b1;
        enable      = 1'b0;
        left_valid  = 1'b0;
        right_valid = 1'b0;
        left_sof    = 1'b0;
        right_sof   = 1'b0;
        left_bv     = '0;
        right_bv    = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one joint pair and wait (bounded) for both readys; returns at
    // posedge+1 right after the consuming edge, with the valids dropped.
    task automatic push(input int unsigned seq, input logic sof);
        logic ok;
        ok          = 1'b0;
        left_valid  = 1'b1;
        right_valid = 1'b1;
        left_sof    = sof;
        right_sof   = sof;
        left_bv     = lvec(seq);
        right_bv    = rvec(seq);
        for (int c = 0; c < 8 && !ok; c++) begin
            #1;
            if (left_ready === 1'b1 && right_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        left_valid  = 1'b0;
        right_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout seq=%0d: readys never both 1 within 8 cycles", seq);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        left_valid = 1'b1;
        right_valid = 1'b1;
        left_sof = 1'b0;
        right_sof = 1'b0;
        left_bv = lvec(1);
        right_bv = rvec(1);
        #1;
        n_checks++;
        if ({bitvec_val, frame_done, sync_err, busy, left_ready, right_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b expected 000000",
                     {bitvec_val, frame_done, sync_err, busy, left_ready, right_ready});
        end
        n_checks++;
        if (input_x !== 10'd0 || input_y !== 10'd0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts got x=%0d y=%0d fc=%0d expected 0 0 0", input_x, input_y, frame_count);
        end
        n_checks++;
        if (left_bitvec !== '0 || right_bitvec !== '0) begin
            n_fail++;
            $display("FAIL reset_bitvec got %h %h expected 0", left_bitvec, right_bitvec);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        // IDLE with enable=0: nothing is consumed even though data is offered.
        @(posedge clk);
        #1;
        n_checks++;
        if (left_ready !== 1'b0 || right_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold got lr=%b rr=%b busy=%b expected 0 0 0", left_ready, right_ready, busy);
        end
        left_valid = 1'b0;
        right_valid = 1'b0;
    endtask

    task automatic test_clean_frame();
        int unsigned ex, ey, fd_cnt;
        apply_reset();
        enable = 1'b1;
        ex = 0;
        ey = 0;
        fd_cnt = 0;
        for (int unsigned k = 0; k < W * H; k++) begin
            push(k, k == 0);
            n_checks++;
            if (bitvec_val !== 1'b1 || input_x !== 10'(ex) || input_y !== 10'(ey) ||
                left_bitvec !== lvec(k) || right_bitvec !== rvec(k)) begin
                n_fail++;
                $display("FAIL clean_pixel k=%0d got val=%b x=%0d y=%0d l=%h r=%h expected 1 %0d %0d %h %h",
                         k, bitvec_val, input_x, input_y, left_bitvec, right_bitvec, ex, ey, lvec(k), rvec(k));
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (k == W * H - 1) begin
                n_checks++;
                if (frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clean_last_done got %b expected 1", frame_done);
                end
            end
            if (ex == W - 1) begin
                ex = 0;
                ey++;
            end else begin
                ex++;
            end
        end
        n_checks++;
        if (fd_cnt !== 1) begin
            n_fail++;
            $display("FAIL clean_done_count got %0d expected 1", fd_cnt);
        end
        n_checks++;
        if (frame_count !== 16'd1 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_bookkeeping got fc=%0d err=%b expected 1 0", frame_count, sync_err);
        end
`ifdef CORRELATE_SEQ_FLUSH_EN
        left_valid = 1'b1;
        right_valid = 1'b1;
        left_sof = 1'b1;
        right_sof = 1'b1;
        left_bv = lvec(9000);
        right_bv = rvec(9000);
        for (int unsigned i = 0; i < D - 1; i++) begin
            #1;
            n_checks++;
            if (left_ready !== 1'b0 || right_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_ready i=%0d got %b %b expected 0 0", i, left_ready, right_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bitvec_val !== 1'b1 || input_x !== 10'(i) || input_y !== 10'd0 ||
                left_bitvec !== '0 || right_bitvec !== '0) begin
                n_fail++;
                $display("FAIL flush_beat i=%0d got val=%b x=%0d y=%0d l=%h r=%h expected 1 %0d 0 0 0",
                         i, bitvec_val, input_x, input_y, left_bitvec, right_bitvec, i);
            end
        end
        left_valid = 1'b0;
        right_valid = 1'b0;
`else
        @(posedge clk);
        #1;
        n_checks++;
        if (bitvec_val !== 1'b0 || frame_done !== 1'b0 || input_x !== 10'(W - 1) || input_y !== 10'(H - 1)) begin
            n_fail++;
            $display("FAIL clean_hold got val=%b done=%b x=%0d y=%0d expected 0 0 %0d %0d",
                     bitvec_val, frame_done, input_x, input_y, W - 1, H - 1);
        end
`endif
        push(9000, 1'b1);
        n_checks++;
        if (bitvec_val !== 1'b1 || input_x !== 10'd0 || input_y !== 10'd0 || frame_done !== 1'b0 ||
            left_bitvec !== lvec(9000)) begin
            n_fail++;
            $display("FAIL next_frame_start got val=%b x=%0d y=%0d done=%b expected 1 0 0 0",
                     bitvec_val, input_x, input_y, frame_done);
        end
    endtask

    task automatic test_skewed_start();
        int unsigned li;
        logic lr;
        apply_reset();
        enable = 1'b1;
        li = 0;
        right_valid = 1'b1;
        right_sof = 1'b1;
        right_bv = rvec(1000);
        left_valid = 1'b1;
        left_sof = 1'b0;
        for (int c = 0; c < 20 && li < 5; c++) begin
            left_bv = lvec(500 + li);
            #1;
            lr = left_ready;
            n_checks++;
            if (right_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL skew_right_stall c=%0d got %b expected 0", c, right_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bitvec_val !== 1'b0) begin
                n_fail++;
                $display("FAIL skew_no_issue c=%0d got %b expected 0", c, bitvec_val);
            end
            if (lr === 1'b1) li++;
        end
        n_checks++;
        if (li != 5) begin
            n_fail++;
            $display("FAIL skew_discard got %0d junk beats consumed expected 5", li);
        end
        push(1000, 1'b1);
        n_checks++;
        if (bitvec_val !== 1'b1 || input_x !== 10'd0 || input_y !== 10'd0 ||
            left_bitvec !== lvec(1000) || right_bitvec !== rvec(1000)) begin
            n_fail++;
            $display("FAIL skew_first_pair got val=%b x=%0d y=%0d l=%h r=%h expected 1 0 0 %h %h",
                     bitvec_val, input_x, input_y, left_bitvec, right_bitvec, lvec(1000), rvec(1000));
        end
    endtask

    // Runs straight after test_skewed_start: the next pixel is (1,0).
    task automatic test_backpressure();
        int unsigned k, ex;
        logic rvld;
        k = 1001;
        ex = 1;
        for (int c = 0; c < 8; c++) begin
            rvld = (c % 2 == 0);
            left_valid = 1'b1;
            right_valid = rvld;
            left_sof = 1'b0;
            right_sof = 1'b0;
            left_bv = lvec(k);
            right_bv = rvec(k);
            #1;
            n_checks++;
            if (left_ready !== rvld || right_ready !== rvld) begin
                n_fail++;
                $display("FAIL bp_ready c=%0d got %b %b expected %b %b", c, left_ready, right_ready, rvld, rvld);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bitvec_val !== rvld) begin
                n_fail++;
                $display("FAIL bp_strobe c=%0d got %b expected %b", c, bitvec_val, rvld);
            end
            if (rvld) begin
                n_checks++;
                if (input_x !== 10'(ex) || input_y !== 10'd0 || left_bitvec !== lvec(k) || right_bitvec !== rvec(k)) begin
                    n_fail++;
                    $display("FAIL bp_pair c=%0d got x=%0d y=%0d l=%h r=%h expected %0d 0 %h %h",
                             c, input_x, input_y, left_bitvec, right_bitvec, ex, lvec(k), rvec(k));
                end
                k++;
                ex++;
            end
        end
        left_valid = 1'b0;
        right_valid = 1'b0;
    endtask

    task automatic test_mismatch();
        apply_reset();
        enable = 1'b1;
        for (int unsigned k = 0; k < 3 * W + 100; k++) push(k, k == 0);
        left_valid = 1'b1;
        right_valid = 1'b1;
        left_sof = 1'b1;
        right_sof = 1'b0;
        left_bv = lvec(7777);
        right_bv = rvec(7777);
        #1;
        n_checks++;
        if (left_ready !== 1'b0 || right_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mm_no_consume got %b %b expected 0 0", left_ready, right_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (sync_err !== 1'b1 || bitvec_val !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mm_flags got err=%b val=%b busy=%b expected 1 0 1", sync_err, bitvec_val, busy);
        end
        // SYNC signature: right non-SOF head is discarded, left SOF head stalls.
        n_checks++;
        if (left_ready !== 1'b0 || right_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mm_sync_state got lr=%b rr=%b expected 0 1", left_ready, right_ready);
        end
        push(2000, 1'b1);
        n_checks++;
        if (bitvec_val !== 1'b1 || input_x !== 10'd0 || input_y !== 10'd0 || sync_err !== 1'b1 ||
            left_bitvec !== lvec(2000) || right_bitvec !== rvec(2000)) begin
            n_fail++;
            $display("FAIL mm_resume got val=%b x=%0d y=%0d err=%b expected 1 0 0 1",
                     bitvec_val, input_x, input_y, sync_err);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        enable = 1'b1;
        for (int unsigned k = 0; k <= 50 * W + 200; k++) push(k, k == 0);
        n_checks++;
        if (bitvec_val !== 1'b1 || input_x !== 10'd200 || input_y !== 10'd50) begin
            n_fail++;
            $display("FAIL ar_position got val=%b x=%0d y=%0d expected 1 200 50", bitvec_val, input_x, input_y);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bitvec_val, frame_done, sync_err, busy, left_ready, right_ready} !== 6'b0 ||
            input_x !== 10'd0 || input_y !== 10'd0 || left_bitvec !== '0 || right_bitvec !== '0) begin
            n_fail++;
            $display("FAIL ar_clear got flags=%b x=%0d y=%0d expected 000000 0 0",
                     {bitvec_val, frame_done, sync_err, busy, left_ready, right_ready}, input_x, input_y);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        enable = 1'b1;
        push(3000, 1'b1);
        n_checks++;
        if (bitvec_val !== 1'b1 || input_x !== 10'd0 || input_y !== 10'd0 || left_bitvec !== lvec(3000)) begin
            n_fail++;
            $display("FAIL ar_restart got val=%b x=%0d y=%0d expected 1 0 0", bitvec_val, input_x, input_y);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_skewed_start();
        test_backpressure();
        test_mismatch();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
